// File: rtl/microwave_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : microwave_pkg
// Purpose  : Shared types and constants for the microwave timer controller:
//            FSM state encoding, BCD digit width, quick-start preset value
//            and a BCD validity helper.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package microwave_pkg;

  localparam int          DIGIT_W           = 4;
  localparam logic [15:0] QUICK_START_VALUE = 16'h0030;
  localparam logic [3:0]  BCD_MAX           = 4'd9;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5,
    CLR   = 3'd6
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/microwave_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : microwave_if
// Purpose  : Bundle of keypad/button, timer-datapath and display signals
//            around the microwave controller.
//   master : front end / timer side (drives keys, buttons, ticks, zero flag)
//   slave  : controller side (drives counter controls, magnetron, beep, state)
// Signals  : key_valid, key_digit, start, stop_clear, door_open, sec_tick,
//            timer_zero (to controller); entry_digits, timer_loadn,
//            timer_clearn, timer_enable, magnetron_on, beep, state (from it)
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface microwave_if import microwave_pkg::*; #(
  parameter int DIGITS = 4
) ();

  logic                        key_valid;
  logic [DIGIT_W-1:0]          key_digit;
  logic                        start;
  logic                        stop_clear;
  logic                        door_open;
  logic                        sec_tick;
  logic                        timer_zero;
  logic [DIGIT_W*DIGITS-1:0]   entry_digits;
  logic                        timer_loadn;
  logic                        timer_clearn;
  logic                        timer_enable;
  logic                        magnetron_on;
  logic                        beep;
  logic [2:0]                  state;

  modport master (
    output key_valid, key_digit, start, stop_clear, door_open, sec_tick, timer_zero,
    input  entry_digits, timer_loadn, timer_clearn, timer_enable, magnetron_on, beep, state
  );

  modport slave (
    input  key_valid, key_digit, start, stop_clear, door_open, sec_tick, timer_zero,
    output entry_digits, timer_loadn, timer_clearn, timer_enable, magnetron_on, beep, state
  );

endinterface
`default_nettype wire

// File: rtl/microwave_entry_shift_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : entry_shift_reg
// Purpose  : DIGITS-deep BCD entry register. A shift pushes a new digit in at
//            digit 0 and drops the most significant digit.
//            Priority: clr > preset > shift.
// Ports    : clock, clear (async reset), shift, clr, preset, digit,
//            preset_value, value
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module entry_shift_reg import microwave_pkg::*; #(
  parameter int DIGITS = 4
) (
  input  wire logic                      clock,
  input  wire logic                      clear,
  input  wire logic                      shift,
  input  wire logic                      clr,
  input  wire logic                      preset,
  input  wire logic [DIGIT_W-1:0]        digit,
  input  wire logic [DIGIT_W*DIGITS-1:0] preset_value,
  output logic      [DIGIT_W*DIGITS-1:0] value
);

  logic [DIGIT_W*DIGITS-1:0] r_value;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (preset) begin
      r_value <= preset_value;
    end else if (shift) begin
      r_value <= {r_value[DIGIT_W*(DIGITS-1)-1:0], digit};
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/microwave_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : microwave_controller
// Purpose  : Sequencing FSM for a cascaded BCD mm:ss down-counter chain.
//            Collects keypad digits, loads/clears the counters, gates the
//            1 Hz count enable, drives the magnetron and the done beep.
// Ports    : clock, clear (async active-high reset), bus (microwave_if.slave)
// Options  : QUICK_START_EN - when defined, start in IDLE with the door
//            closed presets 00:30 and starts cooking.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module microwave_controller import microwave_pkg::*; #(
  parameter int DIGITS     = 4,
  parameter int BEEP_TICKS = 3
) (
  input wire logic   clock,
  input wire logic   clear,
  microwave_if.slave bus
);

  localparam int                CW          = $clog2(BEEP_TICKS + 1);
  localparam logic [CW-1:0]     C_BEEP_LAST = CW'(BEEP_TICKS - 1);

  state_t                    r_state, w_next;
  logic [CW-1:0]             r_beep_cnt, w_beep_next;
  logic [DIGIT_W*DIGITS-1:0] w_entry;
  logic [DIGIT_W*DIGITS-1:0] w_preset_value;
  logic                      w_shift, w_preset, w_entry_clr;
  logic                      w_loadn, w_clearn, w_enable, w_mag, w_beep;
  logic                      w_key_ok, w_entry_nz;

  assign w_key_ok   = bus.key_valid & is_bcd(bus.key_digit);
  assign w_entry_nz = |w_entry;

`ifdef QUICK_START_EN
  assign w_preset_value = (DIGIT_W*DIGITS)'(QUICK_START_VALUE);
`else
  assign w_preset_value = '0;
`endif

  entry_shift_reg #(.DIGITS(DIGITS)) u_entry (
    .clock        (clock),
    .clear        (clear),
    .shift        (w_shift),
    .clr          (w_entry_clr),
    .preset       (w_preset),
    .digit        (bus.key_digit),
    .preset_value (w_preset_value),
    .value        (w_entry)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state    <= IDLE;
      r_beep_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_beep_cnt <= w_beep_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_beep_next = r_beep_cnt;
    w_shift     = 1'b0;
    w_preset    = 1'b0;
    w_entry_clr = 1'b0;
    w_loadn     = 1'b1;
    w_clearn    = 1'b1;
    w_enable    = 1'b0;
    w_mag       = 1'b0;
    w_beep      = 1'b0;

    case (r_state)
      IDLE, ENTRY: begin
        if (bus.stop_clear) begin
          w_next = CLR;
        end else if (bus.start && !bus.door_open && (r_state == ENTRY) && w_entry_nz) begin
          w_next = LOAD;
`ifdef QUICK_START_EN
        end else if (bus.start && !bus.door_open && (r_state == IDLE)) begin
          w_preset = 1'b1;
          w_next   = LOAD;
`endif
        end else if (w_key_ok) begin
          w_shift = 1'b1;
          w_next  = ENTRY;
        end
      end
      LOAD: begin
        w_loadn = 1'b0;
        w_next  = COOK;
      end
      COOK: begin
        // Enable is suppressed at zero so the chain never wraps 0 -> 9.
        w_enable = bus.sec_tick & ~bus.timer_zero;
        w_mag    = ~bus.door_open;
        if (bus.stop_clear || bus.door_open) begin
          w_next = PAUSE;
        end else if (bus.timer_zero) begin
          w_next = DONE;
        end
      end
      PAUSE: begin
        if (bus.stop_clear) begin
          w_next = CLR;
        end else if (bus.start && !bus.door_open) begin
          w_next = COOK;
        end
      end
      DONE: begin
        w_beep = 1'b1;
        if (bus.stop_clear || bus.door_open) begin
          w_next      = IDLE;
          w_entry_clr = 1'b1;
        end else if (bus.sec_tick) begin
          if (r_beep_cnt == C_BEEP_LAST) begin
            w_next      = IDLE;
            w_entry_clr = 1'b1;
          end else begin
            w_beep_next = r_beep_cnt + 1'b1;
          end
        end
      end
      CLR: begin
        w_clearn    = 1'b0;
        w_entry_clr = 1'b1;
        w_next      = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    // Clearing on entry to CLR as well makes entry_digits read zero during CLR.
    if (w_next == CLR) begin
      w_entry_clr = 1'b1;
    end
    if (w_next != DONE) begin
      w_beep_next = '0;
    end
  end

  assign bus.entry_digits = w_entry;
  assign bus.timer_loadn  = w_loadn;
  assign bus.timer_clearn = w_clearn;
  assign bus.timer_enable = w_enable;
  assign bus.magnetron_on = w_mag;
  assign bus.beep         = w_beep;
  assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_microwave_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_microwave_controller
// Purpose  : Directed self-checking bench for microwave_controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_microwave_controller;

  logic clock;
  logic clear;
  int   checks;
  int   errors;

  microwave_if #(.DIGITS(4)) bus ();

  microwave_controller #(.DIGITS(4), .BEEP_TICKS(3)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    #3;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if (bus.entry_digits !== 16'h0000) begin errors++; $display("FAIL reset_entry got %h want 0000", bus.entry_digits); end
    checks++; if ({bus.timer_loadn, bus.timer_clearn, bus.timer_enable, bus.magnetron_on, bus.beep} !== 5'b11000)
      begin errors++; $display("FAIL reset_outs got %b want 11000", {bus.timer_loadn, bus.timer_clearn, bus.timer_enable, bus.magnetron_on, bus.beep}); end
    step();
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_entry_load();
    press(4'd1);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL entry_state got %0d want 1", bus.state); end
    press(4'd2);
    press(4'd3);
    checks++; if (bus.entry_digits !== 16'h0123) begin errors++; $display("FAIL entry_0123 got %h want 0123", bus.entry_digits); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL load_state got %0d want 2", bus.state); end
    checks++; if (bus.timer_loadn !== 1'b0 || bus.timer_enable !== 1'b0) begin errors++; $display("FAIL load_loadn got %b%b want 00", bus.timer_loadn, bus.timer_enable); end
    step();
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL cook_state got %0d want 3", bus.state); end
    checks++; if (bus.timer_loadn !== 1'b1 || bus.magnetron_on !== 1'b1) begin errors++; $display("FAIL cook_outs got %b%b want 11", bus.timer_loadn, bus.magnetron_on); end
  endtask

  task automatic test_cook_done();
    for (int i = 0; i < 5; i++) begin
      bus.sec_tick = 1'b1;
      #1;
      checks++; if (bus.timer_enable !== 1'b1) begin errors++; $display("FAIL tick_en %0d got %b want 1", i, bus.timer_enable); end
      step();
      bus.sec_tick = 1'b0;
      #1;
      checks++; if (bus.timer_enable !== 1'b0) begin errors++; $display("FAIL tick_idle %0d got %b want 0", i, bus.timer_enable); end
    end
    bus.timer_zero = 1'b1;
    bus.sec_tick   = 1'b1;
    #1;
    checks++; if (bus.timer_enable !== 1'b0) begin errors++; $display("FAIL zero_en got %b want 0", bus.timer_enable); end
    step();
    bus.sec_tick = 1'b0;
    checks++; if (bus.state !== 3'd5 || bus.beep !== 1'b1) begin errors++; $display("FAIL done_state got %0d/%b want 5/1", bus.state, bus.beep); end
    for (int i = 0; i < 2; i++) begin
      bus.sec_tick = 1'b1;
      step();
      bus.sec_tick = 1'b0;
      step();
      checks++; if (bus.state !== 3'd5 || bus.beep !== 1'b1) begin errors++; $display("FAIL beep_hold %0d got %0d/%b want 5/1", i, bus.state, bus.beep); end
    end
    bus.sec_tick = 1'b1;
    step();
    bus.sec_tick   = 1'b0;
    bus.timer_zero = 1'b0;
    checks++; if (bus.state !== 3'd0 || bus.beep !== 1'b0) begin errors++; $display("FAIL beep_end got %0d/%b want 0/0", bus.state, bus.beep); end
    checks++; if (bus.entry_digits !== 16'h0000) begin errors++; $display("FAIL done_entry got %h want 0000", bus.entry_digits); end
  endtask

  task automatic test_pause();
    press(4'd9);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.door_open = 1'b1;
    #1;
    checks++; if (bus.magnetron_on !== 1'b0) begin errors++; $display("FAIL door_mag got %b want 0", bus.magnetron_on); end
    step();
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL pause_state got %0d want 4", bus.state); end
    bus.start = 1'b1;
    step();
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL pause_door_start got %0d want 4", bus.state); end
    bus.door_open = 1'b0;
    step();
    bus.start = 1'b0;
    checks++; if (bus.state !== 3'd3 || bus.timer_loadn !== 1'b1) begin errors++; $display("FAIL resume got %0d/%b want 3/1", bus.state, bus.timer_loadn); end
    checks++; if (bus.entry_digits !== 16'h0009) begin errors++; $display("FAIL resume_entry got %h want 0009", bus.entry_digits); end
    bus.stop_clear = 1'b1;
    step();
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL cook_stop got %0d want 4", bus.state); end
    step();
    bus.stop_clear = 1'b0;
    checks++; if (bus.state !== 3'd6 || bus.timer_clearn !== 1'b0) begin errors++; $display("FAIL pause_clr got %0d/%b want 6/0", bus.state, bus.timer_clearn); end
    step();
  endtask

  task automatic test_keys_clear();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    checks++; if (bus.entry_digits !== 16'h2345) begin errors++; $display("FAIL entry_2345 got %h want 2345", bus.entry_digits); end
    press(4'hA);
    checks++; if (bus.entry_digits !== 16'h2345 || bus.state !== 3'd1) begin errors++; $display("FAIL bad_digit got %h/%0d want 2345/1", bus.entry_digits, bus.state); end
    bus.stop_clear = 1'b1;
    step();
    bus.stop_clear = 1'b0;
    checks++; if (bus.state !== 3'd6 || bus.timer_clearn !== 1'b0 || bus.timer_loadn !== 1'b1) begin errors++; $display("FAIL clr_state got %0d/%b%b want 6/01", bus.state, bus.timer_clearn, bus.timer_loadn); end
    checks++; if (bus.entry_digits !== 16'h0000) begin errors++; $display("FAIL clr_entry got %h want 0000", bus.entry_digits); end
    step();
    checks++; if (bus.state !== 3'd0 || bus.timer_clearn !== 1'b1) begin errors++; $display("FAIL clr_idle got %0d/%b want 0/1", bus.state, bus.timer_clearn); end
  endtask

  task automatic test_priority();
    press(4'd7);
    bus.start      = 1'b1;
    bus.stop_clear = 1'b1;
    step();
    bus.start      = 1'b0;
    bus.stop_clear = 1'b0;
    checks++; if (bus.state !== 3'd6) begin errors++; $display("FAIL prio_clr got %0d want 6", bus.state); end
    step();
    press(4'd7);
    bus.door_open = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.door_open = 1'b0;
    bus.start     = 1'b0;
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL door_start got %0d want 1", bus.state); end
    bus.stop_clear = 1'b1;
    step();
    bus.stop_clear = 1'b0;
    step();
    press(4'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.state !== 3'd1 || bus.entry_digits !== 16'h0000) begin errors++; $display("FAIL zero_start got %0d/%h want 1/0000", bus.state, bus.entry_digits); end
    bus.stop_clear = 1'b1;
    step();
    bus.stop_clear = 1'b0;
    step();
  endtask

  task automatic test_done_abort();
    press(4'd2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.timer_zero = 1'b1;
    step();
    checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL abort_done got %0d want 5", bus.state); end
    bus.door_open = 1'b1;
    step();
    bus.door_open  = 1'b0;
    bus.timer_zero = 1'b0;
    checks++; if (bus.state !== 3'd0 || bus.beep !== 1'b0 || bus.entry_digits !== 16'h0000)
      begin errors++; $display("FAIL abort_idle got %0d/%b/%h want 0/0/0000", bus.state, bus.beep, bus.entry_digits); end
  endtask

  task automatic test_async_clear();
    press(4'd5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.sec_tick = 1'b1;
    #1;
    checks++; if (bus.timer_enable !== 1'b1 || bus.magnetron_on !== 1'b1) begin errors++; $display("FAIL pre_async got %b%b want 11", bus.timer_enable, bus.magnetron_on); end
    #1;
    clear = 1'b1;
    #1;
    checks++; if (bus.state !== 3'd0 || bus.entry_digits !== 16'h0000) begin errors++; $display("FAIL async_state got %0d/%h want 0/0000", bus.state, bus.entry_digits); end
    checks++; if ({bus.timer_loadn, bus.timer_clearn, bus.timer_enable, bus.magnetron_on, bus.beep} !== 5'b11000)
      begin errors++; $display("FAIL async_outs got %b want 11000", {bus.timer_loadn, bus.timer_clearn, bus.timer_enable, bus.magnetron_on, bus.beep}); end
    clear        = 1'b0;
    bus.sec_tick = 1'b0;
    step();
  endtask

  task automatic test_quick_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
`ifdef QUICK_START_EN
    checks++; if (bus.state !== 3'd2 || bus.entry_digits !== 16'h0030) begin errors++; $display("FAIL quick_start got %0d/%h want 2/0030", bus.state, bus.entry_digits); end
`else
    checks++; if (bus.state !== 3'd0 || bus.entry_digits !== 16'h0000) begin errors++; $display("FAIL idle_start got %0d/%h want 0/0000", bus.state, bus.entry_digits); end
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    clear          = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_digit  = 4'd0;
    bus.start      = 1'b0;
    bus.stop_clear = 1'b0;
    bus.door_open  = 1'b0;
    bus.sec_tick   = 1'b0;
    bus.timer_zero = 1'b0;
    test_reset();
    test_entry_load();
    test_cook_done();
    test_pause();
    test_keys_clear();
    test_priority();
    test_done_abort();
    test_async_clear();
    test_quick_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
